// File: rtl/wt_store_wbuf.sv
// rtl/wt_store_wbuf.sv - write-through store buffer with byte merging, in-order drain and TID tracking
module wt_store_wbuf #(
  parameter int DEPTH           = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int TID_W           = 2,
  parameter int MAX_OUTSTANDING = 7
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 st_valid_i,
  output logic                                 st_ready_o,
  input  logic [ADDR_W-1:0]                    st_addr_i,
  input  logic [DATA_W-1:0]                    st_data_i,
  input  logic [DATA_W/8-1:0]                  st_be_i,
  input  logic                                 st_nc_i,
  output logic                                 mem_req_o,
  input  logic                                 mem_gnt_i,
  output logic [ADDR_W-1:0]                    mem_addr_o,
  output logic [DATA_W-1:0]                    mem_data_o,
  output logic [DATA_W/8-1:0]                  mem_be_o,
  output logic [TID_W-1:0]                     mem_tid_o,
  input  logic                                 mem_ack_i,
  input  logic [TID_W-1:0]                     mem_ack_tid_i,
  input  logic [ADDR_W-1:0]                    ld_addr_i,
  output logic                                 ld_hit_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 empty_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int WA_W  = ADDR_W - 3;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NTID  = 1 << TID_W;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_locked;
  logic [DEPTH-1:0]  r_nc;
  logic [WA_W-1:0]   r_waddr [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [BE_W-1:0]   r_be    [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [NTID-1:0]   r_busy;
  logic [OUT_W-1:0]  r_outst;
  logic [TID_W-1:0]  r_tid;
  logic              r_gnt_q;

  logic              w_full, w_merge, w_merge_hit, w_accept, w_alloc, w_gnt, w_ack;
  logic              w_free_any, w_head_busy;
  logic [PTR_W-1:0]  w_merge_idx;
  logic [TID_W-1:0]  w_free_tid;
  logic [WA_W-1:0]   w_st_waddr;
  logic              w_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_unused   = ^{st_addr_i[2:0], ld_addr_i[2:0]};
  assign w_st_waddr = st_addr_i[ADDR_W-1:3];
  assign w_full     = r_valid[r_tail];

  always_comb begin
    w_free_any = 1'b0;
    w_free_tid = '0;
    for (int t = NTID - 1; t >= 0; t--) begin
      if (!r_busy[t]) begin
        w_free_any = 1'b1;
        w_free_tid = TID_W'(t);
      end
    end
  end

  // A locked head keeps requesting with its latched TID; the cycle after a grant stays idle.
  assign mem_req_o  = r_valid[r_head] &
                      (r_locked[r_head] |
                       (w_free_any & (r_outst < OUT_W'(MAX_OUTSTANDING)) & ~r_gnt_q));
  assign mem_tid_o  = r_locked[r_head] ? r_tid : w_free_tid;
  assign mem_addr_o = {r_waddr[r_head], 3'b000};
  assign mem_data_o = r_data[r_head];
  assign mem_be_o   = r_be[r_head];
  assign w_gnt      = mem_req_o & mem_gnt_i;
  assign w_ack      = mem_ack_i & r_busy[mem_ack_tid_i];

  // The head counts as locked already in the cycle its request first rises.
  always_comb begin
    w_merge     = 1'b0;
    w_merge_idx = '0;
    w_head_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_head_busy = (PTR_W'(i) == r_head) & mem_req_o;
      if (r_valid[i] && !r_locked[i] && !r_nc[i] && !w_head_busy &&
          (r_waddr[i] == w_st_waddr)) begin
        w_merge     = 1'b1;
        w_merge_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    ld_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_waddr[i] == ld_addr_i[ADDR_W-1:3])) ld_hit_o = 1'b1;
    end
  end

  assign w_merge_hit   = ~st_nc_i & w_merge;
  assign st_ready_o    = w_merge_hit | ~w_full;
  assign w_accept      = st_valid_i & st_ready_o;
  assign w_alloc       = w_accept & ~w_merge_hit;
  assign outstanding_o = r_outst;
  assign empty_o       = ~(|r_valid) & (r_outst == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= '0;
      r_locked <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_busy   <= '0;
      r_outst  <= '0;
      r_tid    <= '0;
      r_gnt_q  <= 1'b0;
    end else begin
      r_gnt_q <= w_gnt;
      if (mem_req_o && !mem_gnt_i) begin
        r_locked[r_head] <= 1'b1;
        r_tid            <= mem_tid_o;
      end
      if (w_gnt) begin
        r_valid[r_head]  <= 1'b0;
        r_locked[r_head] <= 1'b0;
        r_head           <= ptr_inc(r_head);
      end
      if (w_alloc) begin
        r_valid[r_tail]  <= 1'b1;
        r_locked[r_tail] <= 1'b0;
        r_tail           <= ptr_inc(r_tail);
      end
      r_busy  <= (r_busy | (w_gnt ? (NTID'(1) << mem_tid_o) : '0)) &
                 ~(w_ack ? (NTID'(1) << mem_ack_tid_i) : '0);
      r_outst <= r_outst + OUT_W'(w_gnt) - OUT_W'(w_ack);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_waddr[r_tail] <= w_st_waddr;
      r_data[r_tail]  <= st_data_i;
      r_be[r_tail]    <= st_be_i;
      r_nc[r_tail]    <= st_nc_i;
    end else if (w_accept) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be_i[b]) r_data[w_merge_idx][b*8 +: 8] <= st_data_i[b*8 +: 8];
      end
      r_be[w_merge_idx] <= r_be[w_merge_idx] | st_be_i;
    end
  end
endmodule

// File: doc/wt_store_wbuf.md
Name: wt_store_wbuf

Overview:
Write-through store buffer between the load/store unit's store path and the write-through data cache memory port in the embedded (no-MMU, 32-bit) CVA6 configuration. It holds up to DEPTH stores. It merges byte-enables of cacheable stores to the same 64-bit word, drains entries in FIFO order through a req/gnt handshake, and tracks in-flight writes by transaction ID until they are acknowledged. It also gives the load path a word-address hazard check against buffered stores.

Parameters:
DEPTH, 2, number of buffer entries (>=1)
ADDR_W, 32, store address width (XLEN)
DATA_W, 64, data word width; BE width is DATA_W/8
TID_W, 2, memory transaction ID width; 2**TID_W IDs
MAX_OUTSTANDING, 7, maximum granted-but-unacknowledged writes

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
st_valid_i  in  1  store request valid
st_ready_o  out  1  store accepted this cycle when high with st_valid_i
st_addr_i  in  ADDR_W  byte address; bits [2:0] ignored (word address)
st_data_i  in  DATA_W  store data, lane-aligned
st_be_i  in  DATA_W/8  byte enables
st_nc_i  in  1  non-cacheable store; never merged
mem_req_o  out  1  write request to memory
mem_gnt_i  in  1  grant; transfer when mem_req_o and mem_gnt_i are both high
mem_addr_o  out  ADDR_W  word-aligned address ([2:0]=0)
mem_data_o  out  DATA_W  write data
mem_be_o  out  DATA_W/8  write byte enables
mem_tid_o  out  TID_W  transaction ID
mem_ack_i  in  1  write acknowledge
mem_ack_tid_i  in  TID_W  ID being acknowledged
ld_addr_i  in  ADDR_W  load address for hazard check
ld_hit_o  out  1  a valid entry matches ld_addr_i word address
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight write count
empty_o  out  1  no valid entries and outstanding_o==0

Behaviour:
- Reset (async, rst_ni low): all entries invalid, FIFO pointers 0, TID busy bitmap 0, outstanding 0, head unlocked. Outputs after reset: mem_req_o=0, st_ready_o=1, ld_hit_o=0, outstanding_o=0, empty_o=1. Reset mid-transfer discards all entries and in-flight tracking. Acks that arrive after reset are ignored.
- Entry fields: valid, word address, data, be, nc, locked.
- Merge hit: st_valid_i, !st_nc_i, and a valid, unlocked, non-nc entry with an equal word address. On acceptance, for each byte with be set, the data byte is overwritten and the be bit is ORed in. Ordering position is unchanged. At most one entry can match; allocation prevents duplicates.
- Allocation: no merge hit and not full. The store is written at the tail, and the tail advances modulo DEPTH.
- st_ready_o = merge_hit | !full. It is combinational in st_addr_i/st_nc_i. There is no same-cycle pass-through: a full buffer stays not-ready even when a grant frees the head that cycle.
- Issue: mem_req_o=1 when the head is valid, a free TID exists, and outstanding < MAX_OUTSTANDING. The free TID chosen is the lowest-index one.
- When mem_req_o rises, the head becomes locked. mem_addr/data/be/tid stay stable until the grant. No merge into a locked entry; a store to the same word allocates a new entry.
- On the grant: the head is freed and the head pointer advances. The TID busy bit is set and outstanding increments. The next request can assert the following cycle at the earliest, so there is one idle cycle between back-to-back requests.
- On mem_ack_i with a busy TID: the busy bit clears and outstanding decrements. An ack to a non-busy TID is ignored. A same-cycle grant and ack leaves outstanding net unchanged, and the acked TID may be a different one. A TID freed by an ack is usable for issue the next cycle.
- ld_hit_o: combinational; set when any valid entry's word address equals ld_addr_i[ADDR_W-1:3]. Locked entries count.
- Same-cycle accept and grant: the head update and tail update are independent. With DEPTH=1, accept requires the entry to be empty at the start of the cycle.
- Zero be (st_be_i==0) is accepted and stored/merged normally.

Test Plan:
- Reset, then store addr 0x8000_0010 data 0x11 be 0x01, with mem_gnt_i held 1 -> mem_req_o high the cycle after acceptance, mem_addr_o=0x8000_0010, mem_be_o=0x01, mem_tid_o=0; outstanding_o=1 after the grant; ack tid 0 -> outstanding_o=0, empty_o=1.
- With mem_gnt_i=0 and the head locked, store to 0x8000_0020 be 0x0F, then to 0x8000_0024 be 0xF0 -> second store merges (single entry be=0xFF); a third store to 0x8000_0020 with DEPTH=2 full -> merges into the tail and st_ready_o=1.
- Fill both entries with distinct words, mem_gnt_i=0, apply a third distinct store -> st_ready_o=0; raise the grant for one cycle -> st_ready_o=1 the next cycle.
- Two nc stores to the same word 0x1_0000 -> two separate entries and two requests.
- Never ack, grant always -> exactly 4 requests issued (TIDs 0..3) and mem_req_o stays low. Ack tid 2 -> the next request uses tid 2. A duplicate ack of tid 2 -> outstanding_o unchanged.
- Entry at 0x8000_0040 buffered; ld_addr_i=0x8000_0047 -> ld_hit_o=1; ld_addr_i=0x8000_0048 -> ld_hit_o=0. Assert rst_ni low mid-request -> mem_req_o=0 and empty_o=1 immediately.
